// File: rtl/fetch_if_id_unit.sv
// rtl/fetch_if_id_unit.sv - fetch stage: PC register, IF/ID pipeline register and RUN/HALT control
module fetch_if_id_unit #(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              PCWrite,
    input  logic              Write_IF_ID,
    input  logic              stall_MEM,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              halt_ID,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] instr_ID,
    output logic [WORD_W-1:0] pc_ID,
    output logic [WORD_W-1:0] pc4_ID,
    output logic              valid_ID,
    output logic [4:0]        rsel1_ID,
    output logic [4:0]        rsel2_ID,
    output logic              halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pc_id;
    logic [WORD_W-1:0] r_pc4_id;
    logic              r_valid;

    logic [WORD_W-1:0] w_pc4;
    logic [WORD_W-1:0] w_redirect;

    assign w_pc4      = r_pc + WORD_W'(4);
    assign w_redirect = branch_target & ~(WORD_W'(3));

    // Priority: memory freeze, redirect, halt, IF/ID hold, miss, fetch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= RUN;
            r_pc     <= PC_INIT;
            r_instr  <= '0;
            r_pc_id  <= '0;
            r_pc4_id <= '0;
            r_valid  <= 1'b0;
        end else if (r_state == RUN && !stall_MEM) begin
            if (branch_taken) begin
                r_pc     <= w_redirect;
                r_instr  <= '0;
                r_pc_id  <= '0;
                r_pc4_id <= '0;
                r_valid  <= 1'b0;
            end else if (halt_ID && r_valid) begin
                r_state  <= HALT;
                r_instr  <= '0;
                r_pc_id  <= '0;
                r_pc4_id <= '0;
                r_valid  <= 1'b0;
            end else if (!Write_IF_ID) begin
                r_valid  <= r_valid;
            end else if (!ihit || !PCWrite) begin
                r_instr  <= '0;
                r_pc_id  <= '0;
                r_pc4_id <= '0;
                r_valid  <= 1'b0;
            end else begin
                r_pc     <= w_pc4;
                r_instr  <= imemload;
                r_pc_id  <= r_pc;
                r_pc4_id <= w_pc4;
                r_valid  <= 1'b1;
            end
        end
    end

    assign imemaddr = r_pc;
    assign imemREN  = (r_state == RUN);
    assign halted   = (r_state == HALT);
    assign instr_ID = r_instr;
    assign pc_ID    = r_pc_id;
    assign pc4_ID   = r_pc4_id;
    assign valid_ID = r_valid;

    // Bubbles report r0 so an empty slot cannot look like a register dependency.
    assign rsel1_ID = r_valid ? r_instr[19:15] : 5'd0;
    assign rsel2_ID = r_valid ? r_instr[24:20] : 5'd0;

endmodule

// File: tb/tb_fetch_if_id_unit.sv
// tb/tb_fetch_if_id_unit.sv - directed bench with a reference fetch model and per-cycle compare
module tb_fetch_if_id_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        PCWrite = 1'b0;
    logic        Write_IF_ID = 1'b0;
    logic        stall_MEM = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt_ID = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr_ID;
    logic [31:0] pc_ID;
    logic [31:0] pc4_ID;
    logic        valid_ID;
    logic [4:0]  rsel1_ID;
    logic [4:0]  rsel2_ID;
    logic        halted;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    fetch_if_id_unit dut (
        .CLK(CLK), .nRST(nRST), .PCWrite(PCWrite), .Write_IF_ID(Write_IF_ID),
        .stall_MEM(stall_MEM), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_ID(halt_ID), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
        .imemaddr(imemaddr), .instr_ID(instr_ID), .pc_ID(pc_ID), .pc4_ID(pc4_ID),
        .valid_ID(valid_ID), .rsel1_ID(rsel1_ID), .rsel2_ID(rsel2_ID), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Reference model: architectural view of PC, IF/ID slot and halt flag
    bit [31:0] m_pc, m_instr, m_pcid, m_pc4;
    bit        m_valid, m_halt;

    task automatic m_bubble();
        m_instr = 0; m_pcid = 0; m_pc4 = 0; m_valid = 0;
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_pc = 32'h0; m_halt = 0;
            m_bubble();
        end else if (!m_halt && !stall_MEM) begin
            if (branch_taken) begin
                m_pc = {branch_target[31:2], 2'b00};
                m_bubble();
            end else if (halt_ID && m_valid) begin
                m_halt = 1;
                m_bubble();
            end else if (!Write_IF_ID) begin
                m_pc = m_pc;
            end else if (ihit && PCWrite) begin
                m_instr = imemload; m_pcid = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1;
                m_pc = m_pc + 32'd4;
            end else begin
                m_bubble();
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("m_imemaddr", imemaddr, m_pc);
            cmp("m_imemREN", {31'd0, imemREN}, {31'd0, !m_halt});
            cmp("m_halted", {31'd0, halted}, {31'd0, m_halt});
            cmp("m_valid", {31'd0, valid_ID}, {31'd0, m_valid});
            cmp("m_instr", instr_ID, m_instr);
            cmp("m_pc_ID", pc_ID, m_pcid);
            cmp("m_pc4_ID", pc4_ID, m_pc4);
            cmp("m_rsel1", {27'd0, rsel1_ID}, m_valid ? {27'd0, m_instr[19:15]} : 32'd0);
            cmp("m_rsel2", {27'd0, rsel2_ID}, m_valid ? {27'd0, m_instr[24:20]} : 32'd0);
        end
    end

    task automatic drive(input bit pcw, input bit wif, input bit smem, input bit bt,
                         input logic [31:0] tgt, input bit hid, input bit ih, input logic [31:0] ld);
        PCWrite = pcw; Write_IF_ID = wif; stall_MEM = smem; branch_taken = bt;
        branch_target = tgt; halt_ID = hid; ihit = ih; imemload = ld;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        cmp("rst_addr", imemaddr, 32'h0);
        cmp("rst_ren", {31'd0, imemREN}, 32'd1);
        cmp("rst_valid", {31'd0, valid_ID}, 32'd0);
        cmp("rst_halted", {31'd0, halted}, 32'd0);

        // sequential fetch
        drive(1, 1, 0, 0, 0, 0, 1, 32'h0010_0093);
        cmp("seq_pc0", pc_ID, 32'h0);
        cmp("seq_addr4", imemaddr, 32'h4);
        cmp("seq_valid", {31'd0, valid_ID}, 32'd1);
        drive(1, 1, 0, 0, 0, 0, 1, 32'h0002_8333);
        cmp("seq_pc4", pc_ID, 32'h4);
        cmp("seq_addr8", imemaddr, 32'h8);
        cmp("seq_rsel1", {27'd0, rsel1_ID}, 32'd5);

        // load-use stall
        drive(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        cmp("lu_addr", imemaddr, 32'h8);
        cmp("lu_instr", instr_ID, 32'h0002_8333);
        cmp("lu_rsel1", {27'd0, rsel1_ID}, 32'd5);
        drive(1, 1, 0, 0, 0, 0, 1, 32'h0000_0013);
        cmp("lu_next_pc", pc_ID, 32'h8);
        cmp("lu_next_addr", imemaddr, 32'hC);

        // redirect overriding IF/ID hold and miss
        drive(1, 0, 0, 1, 32'h0000_0103, 0, 0, 0);
        cmp("br_addr", imemaddr, 32'h100);
        cmp("br_valid", {31'd0, valid_ID}, 32'd0);
        cmp("br_rsel", {22'd0, rsel1_ID, rsel2_ID}, 32'd0);

        // memory freeze with redirect pulses
        drive(1, 1, 0, 0, 0, 0, 1, 32'h00A0_0093);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, i[0] == 1'b0, 32'h200, 1, 1, 32'h1234_5678);
        cmp("smem_addr", imemaddr, 32'h104);
        cmp("smem_pc", pc_ID, 32'h100);
        cmp("smem_instr", instr_ID, 32'h00A0_0093);
        drive(1, 1, 0, 1, 32'h300, 0, 1, 0);
        cmp("smem_br", imemaddr, 32'h300);

        // I-cache misses
        drive(1, 1, 0, 1, 32'h40, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        cmp("miss_addr", imemaddr, 32'h40);
        cmp("miss_valid", {31'd0, valid_ID}, 32'd0);
        drive(1, 1, 0, 0, 0, 0, 1, 32'h0000_0013);
        cmp("miss_pc", pc_ID, 32'h40);
        cmp("miss_pc4", pc4_ID, 32'h44);

        // halt with simultaneous redirect redirects instead
        drive(1, 1, 0, 1, 32'h80, 1, 1, 0);
        cmp("hb_addr", imemaddr, 32'h80);
        cmp("hb_halted", {31'd0, halted}, 32'd0);
        drive(1, 1, 0, 0, 0, 0, 1, 32'h0000_006F);
        cmp("hb_pc", pc_ID, 32'h80);
        drive(1, 1, 0, 0, 0, 1, 1, 32'h0000_0013);
        cmp("h_halted", {31'd0, halted}, 32'd1);
        cmp("h_ren", {31'd0, imemREN}, 32'd0);
        cmp("h_valid", {31'd0, valid_ID}, 32'd0);
        for (int i = 0; i < 4; i++) drive(i[0], 1, 0, 1, 32'h500, 1, 1, 32'h0002_8333);
        cmp("h_stay", {31'd0, halted}, 32'd1);
        cmp("h_addr", imemaddr, 32'h84);

        // async reset mid-halt
        nRST = 1'b0;
        #1;
        cmp("ar_halted", {31'd0, halted}, 32'd0);
        cmp("ar_addr", imemaddr, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // halt request on a bubble is ignored
        drive(1, 1, 0, 0, 0, 1, 0, 0);
        cmp("hbub_halted", {31'd0, halted}, 32'd0);

        // PC+4 wraparound
        drive(1, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        cmp("wr_addr", imemaddr, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0, 0, 0, 1, 32'h0000_0013);
        cmp("wr_pc", pc_ID, 32'hFFFF_FFFC);
        cmp("wr_pc4", pc4_ID, 32'h0);
        cmp("wr_addr0", imemaddr, 32'h0);

        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
